// File: rtl/counter_register_if.sv
// counter_register_if: bus-side bundle for counter_register.
// master drives strobes and load data; slave is the register.
interface counter_register_if #(
  parameter int W = 16
);
  logic         clr;
  logic         load;
  logic         incr;
  logic         decr;
  logic         shl;
  logic         shr;
  logic         serial_in;
  logic [W-1:0] input_data;
  logic [W-1:0] register_out;
  logic         zero;
  logic         tc;
  logic         ovf_sticky;

  modport master (
    output clr, load, incr, decr,
    output shl, shr, serial_in,
    output input_data,
    input  register_out, zero,
    input  tc, ovf_sticky
  );

  modport slave (
    input  clr, load, incr, decr,
    input  shl, shr, serial_in,
    input  input_data,
    output register_out, zero,
    output tc, ovf_sticky
  );
endinterface

// File: rtl/counter_register.sv
// counter_register: load/count register with modulus and flags.
// Shift path enabled by COUNTER_REGISTER_SHIFT_EN.
module counter_register #(
  parameter int W        = 16,
  parameter int STEP     = 1,
  parameter int MOD      = 0,
  parameter int SATURATE = 0
) (
  input  logic               clock,
  input  logic               reset,
  counter_register_if.slave  bus
);

  localparam logic [W:0] LIM =
    (MOD == 0) ? ((W+1)'(1) << W)
               : (W+1)'(MOD);
  localparam logic [W:0]   STP = (W+1)'(STEP);
  localparam logic [W-1:0] TOP = W'(LIM - 1'b1);

  logic [W-1:0] val_q = '0;
  logic [W-1:0] val_d;
  logic         tc_q  = 1'b0;
  logic         tc_d;
  logic         ovf_q = 1'b0;
  logic         ovf_d;

  logic [W:0] cur_x;
  logic [W:0] up_x;
  logic [W:0] dn_x;
  logic [W:0] ld_x;

  assign cur_x = {1'b0, val_q};
  assign up_x  = cur_x + STP;
  assign dn_x  = cur_x + LIM - STP;
  assign ld_x  = {1'b0, bus.input_data};

`ifdef COUNTER_REGISTER_SHIFT_EN
  logic [W-1:0] sh_v;
  logic [W:0]   sh_x;

  // Shift candidate; left takes serial_in at LSB, right at MSB.
  always_comb begin
    if (bus.shl)
      sh_v = {val_q[W-2:0], bus.serial_in};
    else
      sh_v = {bus.serial_in, val_q[W-1:1]};
  end

  assign sh_x = {1'b0, sh_v};
`else
  logic unused_shift;
  assign unused_shift = ^{bus.shl, bus.shr,
                          bus.serial_in};
`endif

  // Next state: clr > load > shift > count > hold.
  always_comb begin
    val_d = val_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (bus.clr) begin
      val_d = '0;
      ovf_d = 1'b0;
    end else if (bus.load) begin
      if (ld_x >= LIM) begin
        val_d = TOP;
        ovf_d = 1'b1;
      end else begin
        val_d = bus.input_data;
      end
`ifdef COUNTER_REGISTER_SHIFT_EN
    end else if (bus.shl || bus.shr) begin
      if (bus.shl ^ bus.shr) begin
        if (sh_x >= LIM) begin
          val_d = TOP;
          ovf_d = 1'b1;
        end else begin
          val_d = sh_v;
        end
      end
`endif
    end else if (bus.incr && !bus.decr) begin
      if (up_x >= LIM) begin
        val_d = (SATURATE != 0) ? TOP
                                : W'(up_x - LIM);
        tc_d  = 1'b1;
        ovf_d = 1'b1;
      end else begin
        val_d = W'(up_x);
      end
    end else if (bus.decr && !bus.incr) begin
      if (cur_x < STP) begin
        val_d = (SATURATE != 0) ? '0 : W'(dn_x);
        tc_d  = 1'b1;
        ovf_d = 1'b1;
      end else begin
        val_d = W'(cur_x - STP);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      val_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      val_q <= val_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.register_out = val_q;
  assign bus.zero         = (val_q == '0);
  assign bus.tc           = tc_q;
  assign bus.ovf_sticky   = ovf_q;

endmodule

// File: tb/tb_counter_register.sv
// tb_counter_register: three configurations vs. arithmetic model.
// Directed test-plan steps followed by random strobes.
module tb_counter_register;

  typedef struct {
    longint v;
    bit     tc;
    bit     ovf;
  } mst_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clr = 0, load = 0, incr = 0, decr = 0;
  logic        shl = 0, shr = 0, si = 0;
  logic [15:0] din = '0;

  int errors = 0;
  int checks = 0;

  mst_t m0, m1, m2;

  counter_register_if #(.W(16)) if0 ();
  counter_register_if #(.W(16)) if1 ();
  counter_register_if #(.W(16)) if2 ();

  assign if0.clr = clr;  assign if1.clr = clr;  assign if2.clr = clr;
  assign if0.load = load; assign if1.load = load; assign if2.load = load;
  assign if0.incr = incr; assign if1.incr = incr; assign if2.incr = incr;
  assign if0.decr = decr; assign if1.decr = decr; assign if2.decr = decr;
  assign if0.shl = shl;  assign if1.shl = shl;  assign if2.shl = shl;
  assign if0.shr = shr;  assign if1.shr = shr;  assign if2.shr = shr;
  assign if0.serial_in = si;
  assign if1.serial_in = si;
  assign if2.serial_in = si;
  assign if0.input_data = din;
  assign if1.input_data = din;
  assign if2.input_data = din;

  counter_register #(
    .W(16), .STEP(1), .MOD(0), .SATURATE(0)
  ) dut0 (.clock(clock), .reset(reset), .bus(if0));

  counter_register #(
    .W(16), .STEP(3), .MOD(10), .SATURATE(0)
  ) dut1 (.clock(clock), .reset(reset), .bus(if1));

  counter_register #(
    .W(16), .STEP(1), .MOD(10), .SATURATE(1)
  ) dut2 (.clock(clock), .reset(reset), .bus(if2));

  always #5 clock = ~clock;

  function automatic mst_t nxt(mst_t s, int md,
                               int st, bit sat);
    mst_t   r = s;
    longint lim = (md == 0) ? 65536 : md;
    longint n;
    bit     sh_en = 0;
`ifdef COUNTER_REGISTER_SHIFT_EN
    sh_en = 1;
`endif
    r.tc = 0;
    if (reset || clr) begin
      r.v = 0; r.ovf = 0;
    end else if (load) begin
      if (longint'(din) < lim) r.v = din;
      else begin r.v = lim - 1; r.ovf = 1; end
    end else if (sh_en && (shl || shr)) begin
      if (shl != shr) begin
        if (shl) n = (s.v * 2) % 65536 + si;
        else     n = si * 32768 + s.v / 2;
        if (n >= lim) begin n = lim - 1; r.ovf = 1; end
        r.v = n;
      end
    end else if (incr != decr) begin
      n = incr ? s.v + st : s.v - st;
      if (n >= lim) begin
        r.v = sat ? lim - 1 : n - lim;
        r.tc = 1; r.ovf = 1;
      end else if (n < 0) begin
        r.v = sat ? 0 : n + lim;
        r.tc = 1; r.ovf = 1;
      end else begin
        r.v = n;
      end
    end
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_dut(string tag, logic [15:0] v,
                         logic z, logic t, logic o,
                         mst_t m);
    chk({tag, ".val"}, 32'(v), 32'(m.v));
    chk({tag, ".zero"}, 32'(z), 32'(m.v == 0));
    chk({tag, ".tc"}, 32'(t), 32'(m.tc));
    chk({tag, ".ovf"}, 32'(o), 32'(m.ovf));
  endtask

  task automatic tick();
    @(posedge clock);
    m0 = nxt(m0, 0, 1, 0);
    m1 = nxt(m1, 10, 3, 0);
    m2 = nxt(m2, 10, 1, 1);
    #1;
    chk_dut("d0", if0.register_out, if0.zero,
            if0.tc, if0.ovf_sticky, m0);
    chk_dut("d1", if1.register_out, if1.zero,
            if1.tc, if1.ovf_sticky, m1);
    chk_dut("d2", if2.register_out, if2.zero,
            if2.tc, if2.ovf_sticky, m2);
  endtask

  task automatic drv(bit r, bit c, bit l, bit i,
                     bit d, logic [15:0] dn);
    reset = r; clr = c; load = l;
    incr = i; decr = d; din = dn;
    shl = 0; shr = 0; si = 0;
    tick();
  endtask

  initial begin
    m0 = '{0, 0, 0};
    m1 = '{0, 0, 0};
    m2 = '{0, 0, 0};
    drv(1, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    chk("rst.val", 32'(if0.register_out), 0);
    chk("rst.zero", 32'(if0.zero), 1);

    drv(0, 0, 1, 0, 0, 16'h1234);
    chk("ld1234", 32'(if0.register_out), 32'h1234);
    chk("ld1234.zero", 32'(if0.zero), 0);
    drv(0, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    drv(1, 0, 0, 1, 0, 0);
    chk("midrst.val", 32'(if0.register_out), 0);
    chk("midrst.zero", 32'(if0.zero), 1);

    drv(0, 0, 1, 0, 0, 16'hFFFF);
    drv(0, 0, 0, 1, 0, 0);
    chk("wrapF.val", 32'(if0.register_out), 0);
    chk("wrapF.tc", 32'(if0.tc), 1);
    chk("wrapF.ovf", 32'(if0.ovf_sticky), 1);
    drv(0, 0, 0, 0, 0, 0);
    chk("idle.tc", 32'(if0.tc), 0);
    chk("idle.ovf", 32'(if0.ovf_sticky), 1);
    drv(0, 1, 0, 0, 0, 0);
    chk("clr.ovf", 32'(if0.ovf_sticky), 0);

    drv(0, 0, 1, 0, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    chk("m10.a", 32'(if1.register_out), 3);
    drv(0, 0, 0, 1, 0, 0);
    chk("m10.b", 32'(if1.register_out), 6);
    drv(0, 0, 0, 1, 0, 0);
    chk("m10.c", 32'(if1.register_out), 9);
    chk("m10.c.tc", 32'(if1.tc), 0);
    drv(0, 0, 0, 1, 0, 0);
    chk("m10.d", 32'(if1.register_out), 2);
    chk("m10.d.tc", 32'(if1.tc), 1);
    drv(0, 0, 0, 0, 1, 0);
    chk("m10.dec", 32'(if1.register_out), 9);
    chk("m10.dec.tc", 32'(if1.tc), 1);

    drv(0, 1, 0, 0, 0, 0);
    drv(0, 0, 1, 0, 0, 12);
    chk("sat.ld", 32'(if2.register_out), 9);
    chk("sat.ld.ovf", 32'(if2.ovf_sticky), 1);
    chk("sat.ld.tc", 32'(if2.tc), 0);
    drv(0, 0, 0, 1, 0, 0);
    chk("sat.inc", 32'(if2.register_out), 9);
    chk("sat.inc.tc", 32'(if2.tc), 1);
    for (int k = 0; k < 10; k++) drv(0, 0, 0, 0, 1, 0);
    chk("sat.dec", 32'(if2.register_out), 0);
    chk("sat.dec.tc", 32'(if2.tc), 1);

    drv(0, 0, 1, 1, 0, 5);
    chk("sim.ldinc", 32'(if0.register_out), 5);
    drv(0, 0, 0, 1, 1, 0);
    chk("sim.both", 32'(if0.register_out), 5);
    chk("sim.both.tc", 32'(if0.tc), 0);
    drv(0, 1, 1, 0, 0, 7);
    chk("sim.clrld", 32'(if0.register_out), 0);
    chk("sim.clrld.ovf", 32'(if2.ovf_sticky), 0);
    drv(0, 0, 1, 0, 0, 3);
    drv(1, 0, 1, 0, 0, 7);
    chk("sim.rstld", 32'(if0.register_out), 0);

    drv(0, 0, 1, 0, 0, 16'h8001);
    reset = 0; load = 0; shl = 1; si = 1;
    tick();
`ifdef COUNTER_REGISTER_SHIFT_EN
    chk("shl", 32'(if0.register_out), 32'h0003);
`else
    chk("shl", 32'(if0.register_out), 32'h8001);
`endif
    shl = 0; shr = 1; si = 1;
    tick();
    chk("shr", 32'(if0.register_out), 32'h8001);
    shr = 0;

    for (int k = 0; k < 1500; k++) begin
      reset = ($urandom_range(0, 63) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      load  = ($urandom_range(0, 5) == 0);
      shl   = ($urandom_range(0, 3) == 0);
      shr   = ($urandom_range(0, 3) == 0);
      si    = 1'($urandom);
      incr  = 1'($urandom);
      decr  = 1'($urandom);
      din   = $urandom_range(0, 1) != 0
              ? 16'($urandom_range(0, 15))
              : 16'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_register.md
Name: counter_register

Overview:
- Parametrised successor to the basic load/increment register of the datapath, for PC, AR and SC-style registers.
- Adds:
  - up/down counting with programmable step
  - modulus (terminal count) with wrap or saturate mode
  - synchronous clear
  - zero, terminal-count and sticky overflow flags
- Sits on the common bus; loads from bus data and drives its value back to bus and control logic.

Parameters:
- W, 16, data width in bits (W >= 2).
- STEP, 1, increment/decrement amount; 1 <= STEP < LIMIT.
- MOD, 0, count modulus; 0 means LIMIT = 2^W, else LIMIT = MOD. Legal range 2 <= MOD <= 2^W.
- SATURATE, 0, 0 = wrap at limits, 1 = hold at limits.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- clr  in  1  synchronous clear strobe
- load  in  1  load input_data
- incr  in  1  count up by STEP
- decr  in  1  count down by STEP
- input_data  in  W  parallel load value
- shl  in  1  shift left (SHIFT_EN only)
- shr  in  1  shift right (SHIFT_EN only)
- serial_in  in  1  bit shifted in (SHIFT_EN only)
- register_out  out  W  current value, registered
- zero  out  1  register_out == 0, combinational from register
- tc  out  1  registered pulse: wrap or saturate event occurred on the previous edge
- ovf_sticky  out  1  set on any tc event or clamped load; cleared by reset/clr

Behaviour:
- Clock and reset:
  - Single clock, all state updates on the rising edge.
  - reset is synchronous and active-high.
  - Reset values: register_out = 0, tc = 0, ovf_sticky = 0. zero therefore reads 1.
  - Simulation initial value of register_out = 0.
- Priority per edge: reset > clr > load > shl/shr > (incr xor decr) > hold.
  - clr: register_out = 0, ovf_sticky = 0, tc = 0.
  - incr and decr both high: hold, tc = 0.
- Load:
  - If input_data < LIMIT, store input_data.
  - Else store LIMIT-1 and set ovf_sticky; tc = 0.
  - With MOD = 0, the clamp never occurs.
- Increment:
  - Compute sum = register_out + STEP in W+1 bits.
  - sum < LIMIT: store sum, tc = 0.
  - sum >= LIMIT:
    - wrap mode: store sum - LIMIT.
    - saturate mode: store LIMIT-1.
    - Either mode: tc = 1, ovf_sticky = 1.
  - Saturate mode with register_out already at LIMIT-1: value holds, tc = 1 again on each incr.
- Decrement:
  - register_out >= STEP: store register_out - STEP, tc = 0.
  - register_out < STEP:
    - wrap mode: store register_out + LIMIT - STEP (W+1-bit arithmetic).
    - saturate mode: store 0.
    - Either mode: tc = 1, ovf_sticky = 1.
- tc:
  - One-cycle registered pulse, reasserted each qualifying edge.
  - Idle and load cycles drive tc = 0.
- ovf_sticky is only cleared by reset or clr; load does not clear it.
- Latency: value and flags visible one edge after the strobe.
- No X propagation: unused strobes are treated as 0.

Optional Feature:
- Macro: COUNTER_REGISTER_SHIFT_EN.
- Defined:
  - shl: register_out = {register_out[W-2:0], serial_in}.
  - shr: register_out = {serial_in, register_out[W-1:1]}.
  - shl and shr both high: hold.
  - Shift results >= LIMIT (MOD != 0) are clamped to LIMIT-1 and set ovf_sticky.
  - A shift cycle drives tc = 0.
- Not defined: shl, shr and serial_in remain in the port list but are ignored; the interface is identical in both builds.

Test Plan:
- Defaults, reset held 2 cycles then load=1, input_data=16'h1234 -> register_out=16'h1234 next edge, zero=0, tc=0; assert reset mid-count -> register_out=0, zero=1, ovf_sticky=0 next edge.
- Defaults, load 16'hFFFF then incr -> register_out=16'h0000, tc=1 for exactly one cycle, ovf_sticky=1; following idle cycle tc=0, ovf_sticky stays 1 until clr.
- MOD=10, STEP=3, wrap: load 0, incr x4 -> 3, 6, 9, 2 with tc on the fourth edge; then decr -> 9 (2+10-3), tc=1.
- MOD=10, SATURATE=1: load 12 -> register_out=9, ovf_sticky=1; incr -> 9, tc=1; decr x10 with STEP=1 -> reaches 0, next decr stays 0, tc=1.
- Simultaneous events: load=1, incr=1, input_data=5 -> 5; incr=decr=1 -> hold; clr=1, load=1 -> 0, ovf_sticky=0; reset=1, clr=0, load=1 -> 0.
- COUNTER_REGISTER_SHIFT_EN, defaults: load 16'h8001, shl with serial_in=1 -> 16'h0003; shr with serial_in=1 -> 16'h8001; without macro, same stimulus -> register_out unchanged at 16'h8001.
